// File: rtl/fm_pkg.sv
// Shared constants for the FM transmit sequencer.
// The state encoding is exported on seq_state, so it is pinned here.
package fm_pkg;

  localparam int REG_SIZE    = 25;
  localparam int AUDIO_WIDTH = 16;
  localparam int PHASE_INC   = 13681057;
  localparam int GAIN_W      = 5;

  typedef logic [1:0] st_t;

  localparam st_t ST_IDLE = 2'd0;
  localparam st_t ST_RAMP = 2'd1;
  localparam st_t ST_RUN  = 2'd2;
  localparam st_t ST_MUTE = 2'd3;

endpackage

// File: rtl/fm_seq_watchdog.sv
// Strobe watchdog: counts enabled cycles since the last clear and
// flags expiry while the count sits at TIMEOUT_CYCLES-1.
module fm_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic clk10m,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable)
      cnt_d = '0;
    else if (cnt_q != LAST)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk10m or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // Expiry is independent of clear so the caller can let a strobe win.
  assign expire = enable && (cnt_q == LAST);

endmodule

// File: rtl/fm_tx_sequencer.sv
// FM carrier sequencer: IDLE/RAMP/RUN/MUTE control of the DDS increment.
// FM_SEQ_RAMP_EN enables the soft gain ramp; otherwise start is direct to RUN.
module fm_tx_sequencer #(
  parameter int REG_SIZE       = fm_pkg::REG_SIZE,
  parameter int AUDIO_WIDTH    = fm_pkg::AUDIO_WIDTH,
  parameter int PHASE_INC      = fm_pkg::PHASE_INC,
  parameter int DEV_SHIFT      = 4,
  parameter int TIMEOUT_CYCLES = 2048,
  parameter int RAMP_STEP      = 64
) (
  input  logic                   clk10m,
  input  logic                   rst,
  input  logic                   tx_enable,
  input  logic [AUDIO_WIDTH-1:0] sample_in,
  input  logic                   sample_strobe,
  output logic [REG_SIZE-1:0]    inc_value,
  output logic                   carrier_en,
  output logic [1:0]             seq_state,
  output logic [7:0]             underrun_cnt
);

  import fm_pkg::GAIN_W;
  import fm_pkg::st_t;
  import fm_pkg::ST_IDLE;
  import fm_pkg::ST_RAMP;
  import fm_pkg::ST_RUN;
  import fm_pkg::ST_MUTE;

  localparam int PW = AUDIO_WIDTH + GAIN_W + 1;
  localparam int RW = (RAMP_STEP > 2) ? $clog2(RAMP_STEP) : 1;

  localparam logic [RW-1:0]       RAMP_LAST = RW'(RAMP_STEP - 1);
  localparam logic [REG_SIZE-1:0] CENTRE    = REG_SIZE'(PHASE_INC);
  localparam logic [GAIN_W-1:0]   GAIN_FULL = GAIN_W'(16);
  localparam logic [GAIN_W-1:0]   GAIN_PRE  = GAIN_W'(15);

`ifdef FM_SEQ_RAMP_EN
  localparam st_t               ST_START = ST_RAMP;
  localparam logic [GAIN_W-1:0] GAIN_RST = '0;
`else
  localparam st_t               ST_START = ST_RUN;
  localparam logic [GAIN_W-1:0] GAIN_RST = GAIN_FULL;
`endif

  st_t                  state_q, state_d;
  logic [REG_SIZE-1:0]  inc_q, inc_d;
  logic                 carrier_q, carrier_d;
  logic [GAIN_W-1:0]    gain_q, gain_d;
  logic [RW-1:0]        ramp_q, ramp_d;
  logic [7:0]           und_q, und_d;

  logic                 active;
  logic                 gain_step;
  logic                 ramp_full;
  logic                 expire;
  logic                 wd_clear;

  logic signed [AUDIO_WIDTH-1:0] smp_s;
  logic signed [GAIN_W:0]        gain_s;
  logic signed [PW-1:0]          prod;
  logic signed [PW-1:0]          scaled;
  logic signed [PW-1:0]          dev;
  logic [REG_SIZE-1:0]           dev_ext;

  assign active    = (state_q == ST_RAMP) || (state_q == ST_RUN);
  assign gain_step = sample_strobe && (state_q == ST_RAMP) &&
                     (ramp_q == RAMP_LAST);
  assign ramp_full = gain_step && (gain_q == GAIN_PRE);

  assign smp_s   = $signed(sample_in);
  assign gain_s  = $signed({1'b0, gain_q});
  assign prod    = PW'(smp_s) * PW'(gain_s);
  assign scaled  = prod >>> 4;
  assign dev     = scaled >>> DEV_SHIFT;
  assign dev_ext = REG_SIZE'(dev);

  // Any state change restarts the strobe watchdog.
  assign wd_clear = sample_strobe || (state_d != state_q);

  fm_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk10m(clk10m),
    .rst   (rst),
    .clear (wd_clear),
    .enable(active),
    .expire(expire)
  );

  always_ff @(posedge clk10m or posedge rst) begin
    if (rst)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!tx_enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_START;
        ST_RAMP: begin
          if (sample_strobe) begin
            if (ramp_full)
              state_d = ST_RUN;
          end else if (expire) begin
            state_d = ST_MUTE;
          end
        end
        ST_RUN: begin
          if (!sample_strobe && expire)
            state_d = ST_MUTE;
        end
        ST_MUTE: begin
          if (sample_strobe)
            state_d = ST_START;
        end
      endcase
    end
  end

  always_comb begin
    inc_d     = inc_q;
    carrier_d = (state_d != ST_IDLE);
    gain_d    = gain_q;
    ramp_d    = ramp_q;
    und_d     = und_q;

    if (state_d == ST_IDLE || state_d == ST_MUTE)
      inc_d = CENTRE;
    else if (active && sample_strobe)
      inc_d = CENTRE + dev_ext;

    if (state_d == ST_IDLE) begin
      gain_d = GAIN_RST;
      ramp_d = '0;
    end else if (state_d == ST_RAMP && state_q != ST_RAMP) begin
      gain_d = '0;
      ramp_d = '0;
    end else if (state_q == ST_RAMP && sample_strobe) begin
      ramp_d = ramp_q + RW'(1);
      if (gain_step) begin
        ramp_d = '0;
        gain_d = gain_q + GAIN_W'(1);
      end
    end

    if (active && state_d == ST_MUTE && und_q != 8'hFF)
      und_d = und_q + 8'd1;
  end

  always_ff @(posedge clk10m or posedge rst) begin
    if (rst) begin
      inc_q     <= CENTRE;
      carrier_q <= 1'b0;
      gain_q    <= GAIN_RST;
      ramp_q    <= '0;
      und_q     <= '0;
    end else begin
      inc_q     <= inc_d;
      carrier_q <= carrier_d;
      gain_q    <= gain_d;
      ramp_q    <= ramp_d;
      und_q     <= und_d;
    end
  end

  assign inc_value    = inc_q;
  assign carrier_en   = carrier_q;
  assign seq_state    = state_q;
  assign underrun_cnt = und_q;

endmodule

// File: tb/tb_fm_tx_sequencer.sv
// Directed bench for fm_tx_sequencer; a second instance with a short
// timeout exercises underrun counter saturation.
module tb_fm_tx_sequencer;

  localparam logic [24:0] PINC  = 25'd13681057;
  localparam logic [24:0] PPLUS = 25'd13682057;
  localparam logic [24:0] PMIN  = 25'd13680057;
`ifdef FM_SEQ_RAMP_EN
  localparam logic [1:0]  ST_START = 2'd1;
  localparam logic [24:0] EXP_MOD  = PINC;
`else
  localparam logic [1:0]  ST_START = 2'd2;
  localparam logic [24:0] EXP_MOD  = PPLUS;
`endif

  logic        clk10m = 1'b0;
  logic        rst;
  logic        tx_enable;
  logic [15:0] sample_in;
  logic        sample_strobe;
  logic [24:0] inc_value;
  logic        carrier_en;
  logic [1:0]  seq_state;
  logic [7:0]  underrun_cnt;

  logic        tx2;
  logic [15:0] sample2;
  logic        strobe2;
  logic [24:0] inc2;
  logic        car2;
  logic [1:0]  st2;
  logic [7:0]  und2;

  int checks = 0;
  int errors = 0;

  always #5 clk10m = ~clk10m;

  fm_tx_sequencer dut (
    .clk10m       (clk10m),
    .rst          (rst),
    .tx_enable    (tx_enable),
    .sample_in    (sample_in),
    .sample_strobe(sample_strobe),
    .inc_value    (inc_value),
    .carrier_en   (carrier_en),
    .seq_state    (seq_state),
    .underrun_cnt (underrun_cnt)
  );

  fm_tx_sequencer #(
    .TIMEOUT_CYCLES(16),
    .RAMP_STEP     (2)
  ) dut2 (
    .clk10m       (clk10m),
    .rst          (rst),
    .tx_enable    (tx2),
    .sample_in    (sample2),
    .sample_strobe(strobe2),
    .inc_value    (inc2),
    .carrier_en   (car2),
    .seq_state    (st2),
    .underrun_cnt (und2)
  );

  task automatic tick();
    @(posedge clk10m);
    #1;
  endtask

  task automatic strobe(input logic [15:0] s);
    sample_in = s;
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_enable = 1'b0;
    sample_in = '0;
    sample_strobe = 1'b0;
    tx2 = 1'b0;
    sample2 = '0;
    strobe2 = 1'b0;
    repeat (2) tick();
    checks++;
    if (seq_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d want 0", seq_state);
    end
    checks++;
    if (inc_value !== PINC) begin
      errors++;
      $display("FAIL reset_inc: got %0d want %0d", inc_value, PINC);
    end
    checks++;
    if (carrier_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_carrier: got %0b want 0", carrier_en);
    end
    checks++;
    if (underrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_underrun: got %0d want 0", underrun_cnt);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (seq_state !== 2'd0) begin
      errors++;
      $display("FAIL idle_hold: got %0d want 0", seq_state);
    end
  endtask

`ifdef FM_SEQ_RAMP_EN
  task automatic test_ramp();
    tx_enable = 1'b1;
    tick();
    checks++;
    if (seq_state !== 2'd1 || carrier_en !== 1'b1) begin
      errors++;
      $display("FAIL ramp_entry: got st=%0d car=%0b want st=1 car=1",
               seq_state, carrier_en);
    end
    for (int n = 1; n <= 1024; n++) begin
      strobe(16'd16000);
      if (n == 64) begin
        checks++;
        if (inc_value !== PINC) begin
          errors++;
          $display("FAIL ramp_g0: got %0d want %0d", inc_value, PINC);
        end
      end
      if (n == 65) begin
        checks++;
        if (inc_value !== 25'd13681119) begin
          errors++;
          $display("FAIL ramp_g1: got %0d want 13681119", inc_value);
        end
      end
      if (n == 513) begin
        checks++;
        if (inc_value !== 25'd13681557) begin
          errors++;
          $display("FAIL ramp_g8: got %0d want 13681557", inc_value);
        end
      end
      if (n == 1023) begin
        checks++;
        if (seq_state !== 2'd1) begin
          errors++;
          $display("FAIL ramp_hold: got %0d want 1", seq_state);
        end
      end
      if (n == 1024) begin
        checks++;
        if (seq_state !== 2'd2 || inc_value !== 25'd13681994) begin
          errors++;
          $display("FAIL ramp_done: got st=%0d inc=%0d want st=2 inc=13681994",
                   seq_state, inc_value);
        end
      end
      repeat (7) tick();
    end
  endtask
`else
  task automatic test_go_run();
    tx_enable = 1'b1;
    tick();
    checks++;
    if (seq_state !== 2'd2) begin
      errors++;
      $display("FAIL direct_run: got %0d want 2", seq_state);
    end
    checks++;
    if (carrier_en !== 1'b1) begin
      errors++;
      $display("FAIL run_carrier: got %0b want 1", carrier_en);
    end
  endtask
`endif

  task automatic test_modulation();
    strobe(16'd16000);
    checks++;
    if (inc_value !== PPLUS) begin
      errors++;
      $display("FAIL mod_pos: got %0d want %0d", inc_value, PPLUS);
    end
    tick();
    checks++;
    if (inc_value !== PPLUS) begin
      errors++;
      $display("FAIL mod_hold: got %0d want %0d", inc_value, PPLUS);
    end
    strobe(16'hC180);
    checks++;
    if (inc_value !== PMIN) begin
      errors++;
      $display("FAIL mod_neg: got %0d want %0d", inc_value, PMIN);
    end
  endtask

  task automatic test_timeout();
    strobe(16'd16000);
    repeat (2047) tick();
    checks++;
    if (seq_state !== 2'd2 || inc_value !== PPLUS) begin
      errors++;
      $display("FAIL pre_timeout: got st=%0d inc=%0d want st=2 inc=%0d",
               seq_state, inc_value, PPLUS);
    end
    tick();
    checks++;
    if (seq_state !== 2'd3) begin
      errors++;
      $display("FAIL timeout_mute: got %0d want 3", seq_state);
    end
    checks++;
    if (inc_value !== PINC || carrier_en !== 1'b1) begin
      errors++;
      $display("FAIL mute_carrier: got inc=%0d car=%0b want inc=%0d car=1",
               inc_value, carrier_en, PINC);
    end
    checks++;
    if (underrun_cnt !== 8'd1) begin
      errors++;
      $display("FAIL underrun_1: got %0d want 1", underrun_cnt);
    end
  endtask

  task automatic test_mute_exit();
    strobe(16'd16000);
    checks++;
    if (seq_state !== ST_START || inc_value !== PINC) begin
      errors++;
      $display("FAIL mute_exit: got st=%0d inc=%0d want st=%0d inc=%0d",
               seq_state, inc_value, ST_START, PINC);
    end
  endtask

  task automatic test_expiry_strobe();
    strobe(16'd0);
    repeat (2047) tick();
    strobe(16'd0);
    checks++;
    if (seq_state !== ST_START || underrun_cnt !== 8'd1) begin
      errors++;
      $display("FAIL expiry_strobe: got st=%0d und=%0d want st=%0d und=1",
               seq_state, underrun_cnt, ST_START);
    end
    repeat (2047) tick();
    checks++;
    if (seq_state !== ST_START) begin
      errors++;
      $display("FAIL wd_cleared: got %0d want %0d", seq_state, ST_START);
    end
    tick();
    checks++;
    if (seq_state !== 2'd3 || underrun_cnt !== 8'd2) begin
      errors++;
      $display("FAIL second_timeout: got st=%0d und=%0d want st=3 und=2",
               seq_state, underrun_cnt);
    end
  endtask

  task automatic test_disable_strobe();
    strobe(16'd16000);
    strobe(16'd16000);
    checks++;
    if (inc_value !== EXP_MOD) begin
      errors++;
      $display("FAIL pre_disable: got %0d want %0d", inc_value, EXP_MOD);
    end
    tx_enable = 1'b0;
    strobe(16'd16000);
    checks++;
    if (seq_state !== 2'd0 || inc_value !== PINC) begin
      errors++;
      $display("FAIL disable_prio: got st=%0d inc=%0d want st=0 inc=%0d",
               seq_state, inc_value, PINC);
    end
    checks++;
    if (carrier_en !== 1'b0) begin
      errors++;
      $display("FAIL disable_carrier: got %0b want 0", carrier_en);
    end
  endtask

  task automatic test_saturate();
    int k;
    tx2 = 1'b1;
    tick();
    for (int i = 0; i < 300; i++) begin
      k = 0;
      while (st2 != 2'd3 && k < 40) begin
        tick();
        k++;
      end
      if (st2 != 2'd3) begin
        checks++;
        errors++;
        $display("FAIL sat_wait: got st=%0d want 3 within 40 cycles", st2);
        break;
      end
      if (i == 9) begin
        checks++;
        if (und2 !== 8'd10) begin
          errors++;
          $display("FAIL sat_10: got %0d want 10", und2);
        end
      end
      if (i == 254) begin
        checks++;
        if (und2 !== 8'd255) begin
          errors++;
          $display("FAIL sat_255: got %0d want 255", und2);
        end
      end
      strobe2 = 1'b1;
      tick();
      strobe2 = 1'b0;
    end
    checks++;
    if (und2 !== 8'd255) begin
      errors++;
      $display("FAIL sat_final: got %0d want 255", und2);
    end
    tx2 = 1'b0;
  endtask

  task automatic test_rst_mid_run();
    tx_enable = 1'b1;
    tick();
    strobe(16'd16000);
    checks++;
    if (inc_value !== EXP_MOD || underrun_cnt !== 8'd2) begin
      errors++;
      $display("FAIL pre_rst: got inc=%0d und=%0d want inc=%0d und=2",
               inc_value, underrun_cnt, EXP_MOD);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (seq_state !== 2'd0 || carrier_en !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: got st=%0d car=%0b want st=0 car=0",
               seq_state, carrier_en);
    end
    checks++;
    if (inc_value !== PINC || underrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL async_rst_regs: got inc=%0d und=%0d want inc=%0d und=0",
               inc_value, underrun_cnt, PINC);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (seq_state !== 2'd0) begin
      errors++;
      $display("FAIL rst_release: got %0d want 0", seq_state);
    end
    tick();
    checks++;
    if (seq_state !== ST_START || underrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL resume: got st=%0d und=%0d want st=%0d und=0",
               seq_state, underrun_cnt, ST_START);
    end
  endtask

  initial begin
    test_reset();
`ifdef FM_SEQ_RAMP_EN
    test_ramp();
`else
    test_go_run();
`endif
    test_modulation();
    test_timeout();
    test_mute_exit();
    test_expiry_strobe();
    test_disable_strobe();
    test_saturate();
    test_rst_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule
